// File: rtl/fifo_ring.sv
// fifo_ring: circular-buffer FIFO that uses the io881 strobe handshake.
// It has an occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags that clr_err clears. Reset is synchronous and
// active-low.
// Optional macro FIFO_BYPASS_EN: when the FIFO is empty, d_in falls through
// combinationally to q in the same cycle it is written.
//
// Handshake: d_in is taken at a posedge when d_in_strobe=1 and the FIFO can
// accept the word (not full, or a pop in the same cycle frees a slot). q is
// valid whenever q_ready=1, and the head word is consumed at a posedge when
// q_out_strobe=1 and q_ready=1. A strobe that cannot be honoured is dropped
// and recorded in the matching sticky error flag.
module fifo_ring #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = 3,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 d_in_strobe,
  output logic [WIDTH-1:0]     q,
  output logic                 q_ready,
  input  logic                 q_out_strobe,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  // Thresholds are clamped into 0..DEPTH so that extreme margins still give
  // well-defined constant flags.
  localparam int AF_LEVEL = (DEPTH - AF_MARGIN < 0) ? 0 : (DEPTH - AF_MARGIN);
  localparam int AE_LEVEL = (AE_MARGIN > DEPTH) ? DEPTH :
                            ((AE_MARGIN < 0) ? -1 : AE_MARGIN);
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_CNT   = (ADDR_BITS+1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_CNT   = (ADDR_BITS+1)'((AE_LEVEL < 0) ? 0 : AE_LEVEL);
  localparam bit                 AE_NEVER = (AE_LEVEL < 0);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count_r;
  logic                 overflow_r;
  logic                 underflow_r;

  logic pop;          // head word leaves (through memory or through the bypass path)
  logic push;         // d_in is written into memory
  logic mem_pop;      // rd_ptr advances
  logic direct;       // bypass: word goes straight from d_in to the consumer
  logic ovf_evt;
  logic unf_evt;

  // Status flags all come from the registered count.
  assign empty        = (count_r == '0);
  assign full         = (count_r == FULL_CNT);
  assign almost_full  = (count_r >= AF_CNT);
  assign almost_empty = AE_NEVER ? 1'b0 : (count_r <= AE_CNT);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // Head-of-queue presentation and the events for this cycle.
  always_comb begin
    q       = '0;
    q_ready = !empty;
    direct  = 1'b0;
    if (!empty) begin
      q = mem[rd_ptr];
    end
`ifdef FIFO_BYPASS_EN
    if (empty && d_in_strobe) begin
      q       = d_in;
      q_ready = 1'b1;
      direct  = q_out_strobe;
    end
`endif
    pop     = q_out_strobe && q_ready;
    push    = d_in_strobe && (!full || pop) && !direct;
    mem_pop = pop && !direct;
    ovf_evt = d_in_strobe && full && !pop;
    unf_evt = q_out_strobe && !q_ready;
  end

  // Storage write. Memory contents are not reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= d_in;
    end
  end

  // Pointers and occupancy. Pointers wrap through natural ADDR_BITS rollover.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (mem_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !mem_pop)      count_r <= count_r + 1'b1;
      else if (mem_pop && !push) count_r <= count_r - 1'b1;
    end
  end

  // Sticky error flags. A new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_evt)      overflow_r <= 1'b1;
      else if (clr_err) overflow_r <= 1'b0;
      if (unf_evt)      underflow_r <= 1'b1;
      else if (clr_err) underflow_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ring.sv
// tb_fifo_ring: randomized and directed stimulus for fifo_ring. Every output
// is compared each cycle against a queue-based reference model.
module tb_fifo_ring;

  localparam int WIDTH     = 4;
  localparam int DEPTH     = 8;
  localparam int ADDR_BITS = 3;
  localparam int AF_MARGIN = 1;
  localparam int AE_MARGIN = 1;
`ifdef FIFO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [WIDTH-1:0]     d_in;
  logic                 d_in_strobe;
  logic [WIDTH-1:0]     q;
  logic                 q_ready;
  logic                 q_out_strobe;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_BITS:0]   count;
  logic                 overflow;
  logic                 underflow;
  logic                 clr_err;

  fifo_ring #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS),
    .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_in_strobe(d_in_strobe),
    .q(q), .q_ready(q_ready), .q_out_strobe(q_out_strobe),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ov;
  logic             exp_uf;
  int               n_total;
  int               n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge, check outputs,
  // then advance the reference model across the rising edge.
  task automatic step(input logic r, input logic ws, input logic [WIDTH-1:0] wd,
                      input logic rs, input logic ce);
    int               sz;
    logic             rdy;
    logic [WIDTH-1:0] head;
    bit               take;
    bit               acc;
    bit               drct;
    @(negedge clk);
    rst_n = r; d_in_strobe = ws; d_in = wd; q_out_strobe = rs; clr_err = ce;
    #1;
    sz   = exp_q.size();
    rdy  = (sz > 0) || (BYPASS && ws);
    head = (sz > 0) ? exp_q[0] : ((BYPASS && ws) ? wd : '0);
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz >= DEPTH - AF_MARGIN));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE_MARGIN));
    chk("q_ready", 32'(q_ready), 32'(rdy));
    chk("q", 32'(q), 32'(head));
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("underflow", 32'(underflow), 32'(exp_uf));
    if (!r) begin
      exp_q.delete();
      exp_ov = 1'b0;
      exp_uf = 1'b0;
    end else begin
      take = rs && rdy;
      drct = BYPASS && (sz == 0) && ws && rs;
      acc  = ws && ((sz < DEPTH) || take);
      if (!drct) begin
        if (take) void'(exp_q.pop_front());
        if (acc)  exp_q.push_back(wd);
      end
      if (ws && !acc)      exp_ov = 1'b1;
      else if (ce)         exp_ov = 1'b0;
      if (rs && !rdy)      exp_uf = 1'b1;
      else if (ce)         exp_uf = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [WIDTH-1:0] wd);
    step(1'b1, 1'b1, wd, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clr();
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) wr(WIDTH'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) rd();
  endtask

  initial begin
    rst_n = 1'b0; d_in = '0; d_in_strobe = 1'b0; q_out_strobe = 1'b0; clr_err = 1'b0;
    exp_ov = 1'b0; exp_uf = 1'b0; n_total = 0; n_bad = 0;
    repeat (2) @(posedge clk);

    // reset then idle
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle();
    idle();

    // fill with 1..8, then read back in order
    for (int i = 1; i <= DEPTH; i++) wr(WIDTH'(i));
    idle();
    drain();
    idle();

    // full + write + read in the same cycle
    fill_random();
    step(1'b1, 1'b1, 4'hA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) rd();
    idle();
    rd();
    idle();

    // full + write without read: dropped word, overflow, then clear
    fill_random();
    wr(4'hF);
    idle();
    clr();
    idle();
    drain();
    idle();

    // empty + read; then empty + read + write of 0x5
    rd();
    idle();
    clr();
    step(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
    idle();
    rd();
    clr();
    idle();

    // clear and new error in the same cycle: the error wins
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    idle();
    clr();

    // 20 writes with interleaved reads, bring occupancy to 3, reset
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    while (exp_q.size() > 3) rd();
    while (exp_q.size() < 3) wr(WIDTH'($urandom));
    step(1'b0, 1'b1, 4'h7, 1'b1, 1'b0);
    idle();
    wr(4'h9);
    rd();
    idle();

    // random traffic with occasional reset and error clears
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 99) < 55),
           WIDTH'($urandom),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 9) == 0));
    end
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
